// File: rtl/video_mode_sequencer.sv
// rtl/video_mode_sequencer.sv - video timing mode detector with debounced commit (optional mute: VIDEO_MODE_MUTE_EN)
module video_mode_sequencer #(
    parameter int STABLE_FRAMES = 3,
    parameter int MUTE_FRAMES   = 2,
    parameter int WDOG_BITS     = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       de_h,
    input  logic       de_v,
    input  logic       hs_in,
    input  logic       vs_in,
    output logic [1:0] res_h,
    output logic [1:0] res_v,
    output logic       mode_valid,
    output logic       mode_change,
    output logic       mute
);

    localparam int SW = $clog2(STABLE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, MEASURE, CHECK, COMMIT} state_t;

    state_t         state_q;
    logic           hs_q;
    logic           vs_q;
    logic           hs_begin;
    logic           vs_begin;
    logic [8:0]     pix_q;
    logic [8:0]     width_q;
    logic           width_got_q;
    logic [8:0]     lines_q;
    logic [WDOG_BITS-1:0] wdog_q;
    logic           wdog_ovf;
    logic [1:0]     cand_h_q;
    logic [1:0]     cand_v_q;
    logic           cand_valid_q;
    logic [SW-1:0]  stable_q;
    logic [1:0]     res_h_q;
    logic [1:0]     res_v_q;
    logic           mode_valid_q;
    logic           mode_change_q;

    logic [1:0]     cand_h_d;
    logic [1:0]     cand_v_d;
    logic           frame_bad;
    logic           same_cand;
    logic [SW-1:0]  stable_d;
    logic           commit_d;
    logic           meas_clear;

    assign hs_begin   = hs_q & ~hs_in;
    assign vs_begin   = vs_q & ~vs_in;
    assign wdog_ovf   = &wdog_q;
    assign meas_clear = (state_q == IDLE) || (state_q == CHECK);

    // Sync inputs are idle-high, so the history registers reset high to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            hs_q <= hs_in;
            vs_q <= vs_in;
        end
    end

    // Active pixels on the current line, saturating, restarted at each hsync.
    always_ff @(posedge clk) begin
        if (reset || hs_begin) begin
            pix_q <= '0;
        end else if (ce_pix && de_h && (pix_q != 9'd511)) begin
            pix_q <= pix_q + 9'd1;
        end
    end

    // Per-frame width (first non-empty active line) and active line count.
    always_ff @(posedge clk) begin
        if (reset || meas_clear) begin
            width_q     <= '0;
            width_got_q <= 1'b0;
            lines_q     <= '0;
        end else if (hs_begin && de_v) begin
            if (!width_got_q && (pix_q != 9'd0)) begin
                width_q     <= pix_q;
                width_got_q <= 1'b1;
            end
            if (lines_q != 9'd511) begin
                lines_q <= lines_q + 9'd1;
            end
        end
    end

    // Free-running vsync watchdog; all-ones means no vsync for 2^WDOG_BITS clocks.
    always_ff @(posedge clk) begin
        if (reset || vs_begin) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    // Classify the measured frame and decide the debounce outcome for CHECK.
    always_comb begin
        cand_h_d  = 2'd0;
        cand_v_d  = 2'd0;
        if (width_q > 9'd300) begin
            cand_h_d = 2'd2;
        end else if (width_q > 9'd252) begin
            cand_h_d = 2'd1;
        end
        if (lines_q > 9'd232) begin
            cand_v_d = 2'd2;
        end else if (lines_q > 9'd208) begin
            cand_v_d = 2'd1;
        end
        frame_bad = (width_q == 9'd0) || (lines_q == 9'd0);
        same_cand = cand_valid_q && (cand_h_d == cand_h_q) && (cand_v_d == cand_v_q);
        stable_d  = SW'(1);
        if (same_cand) begin
            stable_d = (stable_q == SW'(STABLE_FRAMES)) ? stable_q : stable_q + 1'b1;
        end
        commit_d  = (stable_d == SW'(STABLE_FRAMES)) &&
                    (!mode_valid_q || (cand_h_d != res_h_q) || (cand_v_d != res_v_q));
    end

    // Mode FSM; the watchdog overrides whatever the FSM decided this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cand_h_q      <= '0;
            cand_v_q      <= '0;
            cand_valid_q  <= 1'b0;
            stable_q      <= '0;
            res_h_q       <= '0;
            res_v_q       <= '0;
            mode_valid_q  <= 1'b0;
            mode_change_q <= 1'b0;
        end else begin
            mode_change_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vs_begin) begin
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (vs_begin) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (frame_bad) begin
                        cand_valid_q <= 1'b0;
                        stable_q     <= '0;
                        state_q      <= MEASURE;
                    end else begin
                        cand_h_q     <= cand_h_d;
                        cand_v_q     <= cand_v_d;
                        cand_valid_q <= 1'b1;
                        stable_q     <= stable_d;
                        state_q      <= commit_d ? COMMIT : MEASURE;
                    end
                end
                COMMIT: begin
                    res_h_q       <= cand_h_q;
                    res_v_q       <= cand_v_q;
                    mode_valid_q  <= 1'b1;
                    mode_change_q <= 1'b1;
                    state_q       <= MEASURE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (wdog_ovf) begin
                state_q      <= IDLE;
                mode_valid_q <= 1'b0;
                stable_q     <= '0;
            end
        end
    end

`ifdef VIDEO_MODE_MUTE_EN
    localparam int MW = $clog2(MUTE_FRAMES + 1);

    logic          mute_q;
    logic [MW-1:0] mute_cnt_q;

    // Mute from each commit until MUTE_FRAMES more vsyncs have passed.
    always_ff @(posedge clk) begin
        if (reset) begin
            mute_q     <= 1'b0;
            mute_cnt_q <= '0;
        end else if (state_q == COMMIT) begin
            mute_q     <= 1'b1;
            mute_cnt_q <= MW'(MUTE_FRAMES);
        end else if (mute_q && vs_begin) begin
            if (mute_cnt_q <= MW'(1)) begin
                mute_q     <= 1'b0;
                mute_cnt_q <= '0;
            end else begin
                mute_cnt_q <= mute_cnt_q - 1'b1;
            end
        end
    end

    assign mute = mute_q;
`else
    // Keeps the parameter referenced in builds without muting.
    logic [31:0] unused_mute_frames;
    assign unused_mute_frames = MUTE_FRAMES;
    assign mute = 1'b0;
`endif

    assign res_h       = res_h_q;
    assign res_v       = res_v_q;
    assign mode_valid  = mode_valid_q;
    assign mode_change = mode_change_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// tb/tb_video_mode_sequencer.sv - directed scoreboard bench for video_mode_sequencer
module tb_video_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic       de_h;
    logic       de_v;
    logic       hs_in;
    logic       vs_in;
    logic [1:0] res_h;
    logic [1:0] res_v;
    logic       mode_valid;
    logic       mode_change;
    logic       mute;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef VIDEO_MODE_MUTE_EN
    localparam logic MUTE_ON = 1'b1;
`else
    localparam logic MUTE_ON = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] rh;
        logic [1:0] rv;
    } exp_t;

    exp_t exp_q[$];

    video_mode_sequencer #(
        .STABLE_FRAMES(3),
        .MUTE_FRAMES  (2),
        .WDOG_BITS    (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .de_h       (de_h),
        .de_v       (de_v),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .res_h      (res_h),
        .res_v      (res_v),
        .mode_valid (mode_valid),
        .mode_change(mode_change),
        .mute       (mute)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_lines(input int w, input int lines);
        de_v = 1'b1;
        for (int l = 0; l < lines; l++) begin
            if (l == 0) begin
                for (int i = 0; i < 2 * w; i++) begin
                    @(negedge clk);
                    de_h   = 1'b1;
                    ce_pix = (i % 2 == 0);
                end
                @(negedge clk);
                de_h   = 1'b0;
                ce_pix = 1'b0;
            end
            @(negedge clk);
            hs_in = 1'b0;
            @(negedge clk);
            hs_in = 1'b1;
            @(negedge clk);
        end
        de_v = 1'b0;
        idle(3);
    endtask

    task automatic send_vsync(input bit exp_chg, input logic [1:0] erh, input logic [1:0] erv);
        exp_t e;
        @(negedge clk);
        vs_in = 1'b0;
        if (exp_chg) begin
            e.cyc = cyc + 3;
            e.rh  = erh;
            e.rv  = erv;
            exp_q.push_back(e);
        end
        idle(3);
        vs_in = 1'b1;
        idle(4);
    endtask

    task automatic frame(input int w, input int lines, input bit exp_chg,
                         input logic [1:0] erh, input logic [1:0] erv);
        send_lines(w, lines);
        send_vsync(exp_chg, erh, erv);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mode_change !== 1'b0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_mode_change observed=1 expected=0 at cyc %0d", cyc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("chg_cycle", cyc, e.cyc);
                    check("chg_res_h", res_h, e.rh);
                    check("chg_res_v", res_v, e.rv);
                    check("chg_valid", mode_valid, 1);
                end
            end
        end
    endtask

    task automatic check_mode(input string tag, input logic [1:0] rh, input logic [1:0] rv,
                              input logic v);
        check({tag, "_res_h"}, res_h, rh);
        check({tag, "_res_v"}, res_v, rv);
        check({tag, "_valid"}, mode_valid, v);
    endtask

    initial begin
        reset  = 1'b1;
        ce_pix = 1'b0;
        de_h   = 1'b0;
        de_v   = 1'b0;
        hs_in  = 1'b1;
        vs_in  = 1'b1;
        idle(4);
        check_mode("reset", 2'd0, 2'd0, 1'b0);
        check("reset_change", mode_change, 0);
        check("reset_mute", mute, 0);
        reset = 1'b0;
        fork
            monitor();
        join_none

        // 320x224 from reset: commit at the end of the fourth frame
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        check("discard_valid", mode_valid, 0);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        frame(320, 224, 1'b1, 2'd2, 2'd1);
        check("t1_pending", exp_q.size(), 0);
        check_mode("t1", 2'd2, 2'd1, 1'b1);
        check("t1_mute_commit", mute, MUTE_ON);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        check("t1_mute_vs1", mute, MUTE_ON);

        // move to 256x240 through a transient 256x224 frame
        frame(256, 224, 1'b0, 2'd0, 2'd0);
        check("t2_mute_vs2", mute, 0);
        check_mode("t2_hold", 2'd2, 2'd1, 1'b1);
        frame(256, 240, 1'b0, 2'd0, 2'd0);
        frame(256, 240, 1'b0, 2'd0, 2'd0);
        check_mode("t2_hold2", 2'd2, 2'd1, 1'b1);
        frame(256, 240, 1'b1, 2'd1, 2'd2);
        check("t2_pending", exp_q.size(), 0);
        check_mode("t2", 2'd1, 2'd2, 1'b1);

        // commit 256x224, then short glitches that must not change it
        frame(256, 224, 1'b0, 2'd0, 2'd0);
        frame(256, 224, 1'b0, 2'd0, 2'd0);
        frame(256, 224, 1'b1, 2'd1, 2'd1);
        check("t3_pending", exp_q.size(), 0);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        frame(256, 224, 1'b0, 2'd0, 2'd0);
        check_mode("t3", 2'd1, 2'd1, 1'b1);

        // a frame without active pixels restarts the debounce
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        frame(0, 224, 1'b0, 2'd0, 2'd0);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        check_mode("t4_hold", 2'd1, 2'd1, 1'b1);
        frame(320, 224, 1'b1, 2'd2, 2'd1);
        check("t4_pending", exp_q.size(), 0);
        check_mode("t4", 2'd2, 2'd1, 1'b1);

        // vsync loss: watchdog drops mode_valid but keeps the resolution
        idle(3000);
        check("wdog_before", mode_valid, 1);
        idle(1500);
        check_mode("wdog_after", 2'd2, 2'd1, 1'b0);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        frame(320, 224, 1'b0, 2'd0, 2'd0);
        check("wdog_novalid", mode_valid, 0);
        frame(320, 224, 1'b1, 2'd2, 2'd1);
        check("t5_pending", exp_q.size(), 0);
        check_mode("t5", 2'd2, 2'd1, 1'b1);

        // reset landing in the COMMIT cycle suppresses the pulse
        frame(256, 240, 1'b0, 2'd0, 2'd0);
        frame(256, 240, 1'b0, 2'd0, 2'd0);
        send_lines(256, 240);
        @(negedge clk);
        vs_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_commit_change", mode_change, 0);
        check_mode("rst_commit", 2'd0, 2'd0, 1'b0);
        check("rst_commit_mute", mute, 0);
        reset = 1'b0;
        idle(2);
        vs_in = 1'b1;
        idle(5);
        check("rst_after_change", mode_change, 0);
        check_mode("rst_after", 2'd0, 2'd0, 1'b0);
        check("final_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_mode_sequencer.md
VIDEO_MODE_SEQUENCER -- requirements
Module: video_mode_sequencer

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 3: consecutive identical frame measurements required before a commit.
REQ-002 SHALL have parameter MUTE_FRAMES, default 2: frames muted after each commit (MUTE_EN builds only).
REQ-003 SHALL have parameter WDOG_BITS, default 21: width of the vsync watchdog counter.
REQ-004 SHALL have port clk  input  1  system clock, the only clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ce_pix  input  1  pixel clock enable, one clk wide.
REQ-007 SHALL have port de_h  input  1  VDP horizontal active display.
REQ-008 SHALL have port de_v  input  1  VDP vertical active display.
REQ-009 SHALL have port hs_in  input  1  hsync, active-low.
REQ-010 SHALL have port vs_in  input  1  vsync, active-low.
REQ-011 SHALL have port res_h  output  2  committed width class: 0=248, 1=256, 2=320.
REQ-012 SHALL have port res_v  output  2  committed height class: 0=192, 1=224, 2=240.
REQ-013 SHALL have port mode_valid  output  1  res_h/res_v hold a committed mode.
REQ-014 SHALL have port mode_change  output  1  one-clk pulse on every commit.
REQ-015 SHALL have port mute  output  1  video mute request; constant 0 without MUTE_EN.

Function
REQ-016 SHALL detect edges by registering hs_in and vs_in: hs_begin = falling edge, vs_begin = falling edge of vs_in.
REQ-017 SHALL count, in a 9-bit saturating counter (max 511), clk cycles where ce_pix & de_h; the counter clears on hs_begin.
REQ-018 SHALL latch the line width at hs_begin of the first line in a frame where de_v=1 and the count is nonzero; later lines do not update it.
REQ-019 SHALL count, in a 9-bit saturating counter, hs_begin events with de_v=1; the counter clears after CHECK.
REQ-020 SHALL classify width: >300 -> 2, >252 -> 1, else 0; height: >232 -> 2, >208 -> 1, else 0.
REQ-021 SHALL run FSM states IDLE, MEASURE, CHECK, COMMIT.
REQ-022 SHALL go IDLE -> MEASURE on the first vs_begin after reset; that first frame is discarded.
REQ-023 SHALL go MEASURE -> CHECK on vs_begin, cycle t, with CHECK in t+1; a simultaneous hs_begin line is included.
REQ-024 In CHECK, SHALL do the following: if width or line count is 0, set the candidate invalid, clear the stable count, and go to MEASURE.
REQ-025 In CHECK, SHALL set stable=1 if the candidate differs from the previous candidate, else increment stable (saturating at STABLE_FRAMES).
REQ-026 In CHECK, SHALL go to COMMIT when stable reaches STABLE_FRAMES and (mode_valid=0 or candidate differs from res_h/res_v); otherwise go to MEASURE.
REQ-027 In COMMIT (cycle t+2), SHALL load res_h/res_v, set mode_valid=1, pulse mode_change for exactly one clk, then go to MEASURE.
REQ-028 SHALL never pulse mode_change when the candidate equals the committed mode.
REQ-029 SHALL clear the watchdog on every vs_begin; on overflow (2^WDOG_BITS clk without vsync) it SHALL clear mode_valid, clear stable, and go to IDLE, keeping res_h/res_v unchanged.
REQ-030 A vs_begin while in CHECK or COMMIT cannot occur (vsync lines are far longer than 2 clk) and needs no handling.

Reset
REQ-031 On reset=1 at a clk edge, SHALL set state=IDLE, res_h=0, res_v=0, mode_valid=0, mode_change=0, mute=0, and clear all counters, candidate and stable.
REQ-032 Reset mid-frame or mid-COMMIT SHALL abort immediately; no mode_change pulse is emitted.

Configuration
REQ-033 Macro VIDEO_MODE_MUTE_EN: when defined, SHALL assert mute from the COMMIT cycle through the vs_begin ending the MUTE_FRAMES-th subsequent frame; a new commit restarts the count.
REQ-034 Without VIDEO_MODE_MUTE_EN, SHALL tie mute to 0 and build no mute counter.

Verification
REQ-035 Reset, then 5 frames of 320 px x 224 lines -> exactly one mode_change, 2 clk after vs_begin ending frame 4; res_h=2, res_v=1, mode_valid=1.
REQ-036 Committed 320x224, then frames of 256x224, 256x240, 256x240, 256x240 -> no pulse until the third 256x240 frame; then res_h=1, res_v=2.
REQ-037 Committed 256x224, then 2 frames of 320x224 and 1 of 256x224 -> no mode_change, outputs unchanged.
REQ-038 Committed mode, then vs_in held high for 2^21 clk -> mode_valid=0, res_h/res_v retained; 4 good frames after that -> recommit.
REQ-039 Frame with de_h never active -> stable cleared; reset asserted in a COMMIT cycle -> mode_change stays 0 and outputs return to 0.
REQ-040 With VIDEO_MODE_MUTE_EN, a commit raises mute in the COMMIT cycle and lowers it at the 2nd following vs_begin; without the macro, mute stays 0 throughout.
